// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_dec_pkg
// Brief  : Shared types, round constants and GF(2^8) helpers for the AES-128
//          decryption core.
// Rev    : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_dec_state_e;

    localparam logic [7:0] c_RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_128_decrypt_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module : aes_inv_sbox
// Brief  : Combinational 8-bit AES inverse S-box (InvSubBytes lane).
// Rev    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [2047:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign byte_o = c_INV_SBOX[11'd2047 - {byte_i, 3'b000} -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_128_decrypt.sv
`default_nettype none
// ============================================================================
// Module : aes_128_decrypt
// Brief  : Iterative AES-128 decryptor, one inverse round per cycle with the
//          key schedule unwound on the fly. Optional k10 cache behind
//          AES_DEC_KEY_CACHE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module aes_128_decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);
    import aes_dec_pkg::*;

    aes_dec_state_e state_q, state_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   rkey_q, rkey_d;
    logic [3:0]     cnt_q, cnt_d;

    logic           w_skip_expand;
    logic [127:0]   w_accept_key;
    logic [31:0]    w_fw0, w_fw1, w_fw2, w_fw3;
    logic [31:0]    w_iw0, w_iw1, w_iw2, w_iw3;
    logic [127:0]   w_fwd_key, w_prev_key;
    logic [127:0]   w_isr, w_isb, w_ark, w_imc, w_round;

    // Forward step k_cnt -> k_cnt+1 and inverse step k_cnt+1 -> k_cnt share rcon[cnt].
    assign w_fw0     = rkey_q[127:96] ^ sub_word({rkey_q[23:0], rkey_q[31:24]}) ^ {c_RCON[cnt_q], 24'h0};
    assign w_fw1     = rkey_q[95:64] ^ w_fw0;
    assign w_fw2     = rkey_q[63:32] ^ w_fw1;
    assign w_fw3     = rkey_q[31:0]  ^ w_fw2;
    assign w_fwd_key = {w_fw0, w_fw1, w_fw2, w_fw3};

    assign w_iw3      = rkey_q[31:0]  ^ rkey_q[63:32];
    assign w_iw2      = rkey_q[63:32] ^ rkey_q[95:64];
    assign w_iw1      = rkey_q[95:64] ^ rkey_q[127:96];
    assign w_iw0      = rkey_q[127:96] ^ sub_word({w_iw3[23:0], w_iw3[31:24]}) ^ {c_RCON[cnt_q], 24'h0};
    assign w_prev_key = {w_iw0, w_iw1, w_iw2, w_iw3};

    for (genvar c = 0; c < 4; c++) begin : g_isr_col
        for (genvar r = 0; r < 4; r++) begin : g_isr_row
            assign w_isr[127-8*(r+4*c) -: 8] = blk_q[127-8*(r+4*((c+4-r)%4)) -: 8];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_isb
        aes_inv_sbox u_isb (
            .byte_i (w_isr[127-8*i -: 8]),
            .byte_o (w_isb[127-8*i -: 8])
        );
    end

    assign w_ark = w_isb ^ w_prev_key;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ark[127-32*c -: 8];
        assign w_a1 = w_ark[119-32*c -: 8];
        assign w_a2 = w_ark[111-32*c -: 8];
        assign w_a3 = w_ark[103-32*c -: 8];
        assign w_imc[127-32*c -: 8] = mul_0e(w_a0) ^ mul_0b(w_a1) ^ mul_0d(w_a2) ^ mul_09(w_a3);
        assign w_imc[119-32*c -: 8] = mul_09(w_a0) ^ mul_0e(w_a1) ^ mul_0b(w_a2) ^ mul_0d(w_a3);
        assign w_imc[111-32*c -: 8] = mul_0d(w_a0) ^ mul_09(w_a1) ^ mul_0e(w_a2) ^ mul_0b(w_a3);
        assign w_imc[103-32*c -: 8] = mul_0b(w_a0) ^ mul_0d(w_a1) ^ mul_09(w_a2) ^ mul_0e(w_a3);
    end

    assign w_round = (cnt_q == 4'd0) ? w_ark : w_imc;

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_vld_q;
    logic [127:0] cache_key_q, cache_k10_q;
    logic         hit_q;
    logic         w_hit, w_accept, w_expand_last;

    assign w_accept      = (state_q == IDLE) && in_valid;
    assign w_hit         = cache_vld_q && (key == cache_key_q);
    assign w_expand_last = (state_q == EXPAND) && !hit_q && (cnt_q == 4'd9);
    assign w_skip_expand = hit_q;
    assign w_accept_key  = w_hit ? cache_k10_q : key;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_k10_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            if (w_accept) begin
                hit_q <= w_hit;
                // A miss invalidates until the new k10 is known.
                if (!w_hit) begin
                    cache_vld_q <= 1'b0;
                    cache_key_q <= key;
                end
            end
            if (w_expand_last) begin
                cache_k10_q <= w_fwd_key;
                cache_vld_q <= 1'b1;
            end
        end
    end
`else
    assign w_skip_expand = 1'b0;
    assign w_accept_key  = key;
`endif

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        rkey_d  = rkey_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = ciphertext;
                    rkey_d  = w_accept_key;
                    cnt_d   = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (w_skip_expand) begin
                    blk_d   = blk_q ^ rkey_q;
                    cnt_d   = 4'd9;
                    state_d = ROUND;
                end else begin
                    rkey_d = w_fwd_key;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        blk_d   = blk_q ^ w_fwd_key;
                        cnt_d   = 4'd9;
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                blk_d  = w_round;
                rkey_d = w_prev_key;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            rkey_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            rkey_q  <= rkey_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign plaintext = (state_q == DONE) ? blk_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_decrypt.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_128_decrypt
// Brief  : Directed + loopback bench for aes_128_decrypt with an expected-result
//          queue and an independent AES-128 encryption model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_aes_128_decrypt;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] ciphertext, key, plaintext;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] pt;
        int           lat;
    } exp_t;
    exp_t sb[$];

    logic [7:0]   sbox_tab [256];
    logic         cache_vld;
    logic [127:0] cache_key;

    localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    aes_128_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [16];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        for (int r = 1; r <= 10; r++) begin
            w[0] = w[0] ^ sbox_tab[w[13]] ^ rc;
            w[1] = w[1] ^ sbox_tab[w[14]];
            w[2] = w[2] ^ sbox_tab[w[15]];
            w[3] = w[3] ^ sbox_tab[w[12]];
            for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row+4*c] = sbox_tab[s[row+4*((c+row)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
        return (cache_vld && cache_key == k) ? 11 : 20;
`else
        return 20;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
        exp_t e;
        e.pt  = pt;
        e.lat = exp_lat(k);
        @(negedge clk);
        chk("in_ready_idle", {127'd0, in_ready}, 128'd1);
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        ciphertext = '0;
        key        = '0;
        sb.push_back(e);
        cache_key  = k;
        cache_vld  = 1'b1;
    endtask

    task automatic recv(input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk("latency", 128'(n), 128'(e.lat));
        chk("plaintext", plaintext, e.pt);
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            in_valid = 1'b0;
            chk("pt_stable", plaintext, e.pt);
            chk("in_ready_bp", {127'd0, in_ready}, 128'd0);
            chk("out_valid_bp", {127'd0, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_hs", {127'd0, in_ready}, 128'd1);
        chk("pt_zero_idle", plaintext, 128'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk, rp;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        key        = '0;
        cache_vld  = 1'b0;
        cache_key  = '0;
        for (int v = 0; v < 256; v++) sbox_tab[v] = calc_sbox(8'(v));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_plaintext", plaintext, 128'd0);

        // out_ready already high when out_valid rises
        out_ready = 1'b1;
        send(c_C1_KEY, c_C1_CT, c_C1_PT);
        chk("busy_running", {127'd0, busy}, 128'd1);
        recv(0);

        send(c_C1_KEY, c_C1_CT, c_C1_PT);
        recv(0);
        send(c_B_KEY, c_B_CT, c_B_PT);
        recv(0);

        send(c_B_KEY, c_B_CT, c_B_PT);
        recv(15);

        // Reset after E15 discards the in-flight block.
        send(c_C1_KEY, c_C1_CT, c_C1_PT);
        repeat (15) @(posedge clk);
        #1;
        chk("busy_mid_round", {127'd0, busy}, 128'd1);
        chk("out_valid_mid_round", {127'd0, out_valid}, 128'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        cache_vld = 1'b0;
        chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
        chk("abort_plaintext", plaintext, 128'd0);
        chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
        send(c_C1_KEY, c_C1_CT, c_C1_PT);
        recv(0);

        for (int i = 0; i < 100; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            send(rk, encrypt(rk, rp), rp);
            recv(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
